// File: rtl/tw_horizontal_loader.sv
// tw_horizontal_loader: collects ENTRIES 128-bit twiddle words and replays them
// as one contiguous 2*ENTRIES-cycle burst on the 64-bit horizontal ROM port,
// high halves first (code 1) then low halves (code 2).
module tw_horizontal_loader #(
    parameter int P_WIDTH       = 128,
    parameter int horizontal_DW = 64,
    parameter int ENTRIES       = 4,
    parameter int CNT_W         = 2
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [P_WIDTH-1:0]       in_data,
    input  logic                     burst_en,
    input  logic                     abort,
    output logic [horizontal_DW-1:0] horizontal_tf_out,
    output logic [1:0]               ROM7_w,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT,
        BURST_HI,
        BURST_LO,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ENTRIES - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   wr_idx, wr_idx_nx;
    logic [CNT_W-1:0]   rd_idx, rd_idx_nx;
    logic [CNT_W-1:0]   wr_addr;
    logic               wr_en;
    logic               handshake;
    logic [P_WIDTH-1:0] words [ENTRIES];

    assign handshake = in_valid & in_ready;
    assign wr_addr   = (state == IDLE) ? '0 : wr_idx;

    // State and index registers
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            state  <= state_nx;
            wr_idx <= wr_idx_nx;
            rd_idx <= rd_idx_nx;
        end
    end

    // Next-state, index and buffer-write decode; abort only honoured before the burst
    always_comb begin
        state_nx  = state;
        wr_idx_nx = wr_idx;
        rd_idx_nx = rd_idx;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    wr_idx_nx = '0;
                end else if (handshake) begin
                    wr_en     = 1'b1;
                    wr_idx_nx = CNT_W'(1);
                    state_nx  = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    wr_idx_nx = '0;
                    state_nx  = IDLE;
                end else if (handshake) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST) begin
                        wr_idx_nx = '0;
                        state_nx  = WAIT;
                    end else begin
                        wr_idx_nx = wr_idx + CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    wr_idx_nx = '0;
                    state_nx  = IDLE;
                end else if (burst_en) begin
                    rd_idx_nx = '0;
                    state_nx  = BURST_HI;
                end
            end
            BURST_HI: begin
                if (rd_idx == LAST) begin
                    rd_idx_nx = '0;
                    state_nx  = BURST_LO;
                end else begin
                    rd_idx_nx = rd_idx + CNT_W'(1);
                end
            end
            BURST_LO: begin
                if (rd_idx == LAST) begin
                    rd_idx_nx = '0;
                    state_nx  = DONE;
                end else begin
                    rd_idx_nx = rd_idx + CNT_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Word buffer; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            words[wr_addr] <= in_data;
        end
    end

    // Registered outputs; in_ready/busy follow the next state so in_ready
    // drops in the same cycle the group becomes complete
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            in_ready          <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            ROM7_w            <= 2'd0;
            horizontal_tf_out <= '0;
        end else begin
            in_ready <= (state_nx == IDLE) || (state_nx == FILL);
            busy     <= (state_nx != IDLE);
            done     <= (state == DONE);
            case (state)
                BURST_HI: begin
                    ROM7_w            <= 2'd1;
                    horizontal_tf_out <= words[rd_idx][P_WIDTH-1:horizontal_DW];
                end
                BURST_LO: begin
                    ROM7_w            <= 2'd2;
                    horizontal_tf_out <= words[rd_idx][horizontal_DW-1:0];
                end
                default: begin
                    ROM7_w            <= 2'd0;
                    horizontal_tf_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/tw_horizontal_loader.md
Name: tw_horizontal_loader

Overview:
- Upstream feeder for the stage-0 twiddle buffer of the 1024-point, 64-lane TW ROM.
- Accepts 128-bit twiddle words ({hi64, lo64}) over a valid/ready handshake and collects a group of ENTRIES words.
- Replays the group as one uninterrupted 2*ENTRIES-cycle burst on the 64-bit horizontal port: all high halves first (write code 1), then all low halves (write code 2).
- Contiguity is required because the ROM's entry counter resets on any idle cycle.

Parameters:
- P_WIDTH, 128, twiddle word width; two packed 64-bit factors.
- horizontal_DW, 64, horizontal port width; equals P_WIDTH/2.
- ENTRIES, 4, words per group; equals the ROM stage-0 entry count.
- CNT_W, 2, index width; log2(ENTRIES).

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  P_WIDTH  twiddle word, [127:64]=hi, [63:0]=lo.
- burst_en  in  1  downstream permits a burst to start (ROM idle, CEN high).
- abort  in  1  synchronous flush of any partial group.
- horizontal_tf_out  out  horizontal_DW  half-word to ROM horizontal_tf_in.
- ROM7_w  out  2  write code: 0 idle, 1 high half, 2 low half.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last low half is issued.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_idx=0; rd_idx=0.
  - Buffer contents are don't-care.
  - Outputs: in_ready=0, ROM7_w=0, horizontal_tf_out=0, busy=0, done=0.
- Outputs are registered. ROM7_w and horizontal_tf_out change together, one cycle after the state/index update.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid & in_ready) stores in_data into buf[0], sets wr_idx=1 and moves to FILL.
- FILL:
  - in_ready=1 while wr_idx<=ENTRIES-1.
  - Each handshake writes buf[wr_idx] and increments wr_idx.
  - The write of index ENTRIES-1 moves to WAIT; in_ready is 0 from the next cycle.
- WAIT:
  - in_ready=0.
  - When burst_en=1, go to BURST_HI with rd_idx=0.
  - If burst_en is already 1 at entry, the burst starts the next cycle.
- BURST_HI:
  - Each cycle drives ROM7_w=1 and horizontal_tf_out=buf[rd_idx][127:64], then increments rd_idx.
  - At rd_idx=ENTRIES-1, wrap rd_idx to 0 and go to BURST_LO.
- BURST_LO:
  - Same as BURST_HI but with ROM7_w=2 and buf[rd_idx][63:0].
  - At rd_idx=ENTRIES-1, go to DONE.
- DONE:
  - For one cycle: done=1, ROM7_w=0, horizontal_tf_out=0.
  - Then return to IDLE.
- Burst timing:
  - The burst is exactly 2*ENTRIES consecutive cycles with ROM7_w!=0. There is no bubble between the HI and LO phases.
  - Once started, burst_en is ignored.
- Stall: in_valid=0 during FILL holds wr_idx. Any gap is legal on the input side.
- abort:
  - In IDLE, FILL or WAIT: next state=IDLE, wr_idx=0, buffered words discarded, no output activity.
  - In BURST_HI or BURST_LO: ignored; the burst completes so the ROM never sees a torn group.
  - In DONE: ignored.
- Simultaneous events:
  - abort together with a handshake: abort wins and the word is dropped. in_ready stays asserted, so the source must treat the word as consumed.
  - burst_en and abort both high in WAIT: abort wins.
- Reset mid-burst: outputs clear immediately (asynchronously), ROM7_w=0. The ROM counter resets itself on the resulting idle cycle.
- ROM7_w never takes the value 3.
- busy=1 in every state except IDLE.

Test Plan:
- Basic load: in_data 0000000000000001_0000000000000001, 0400000000000400_840fa37ec53a39e1, 0000001fffffffe0_00000040003fffc0, 00007fff7fff8000_2e60ca9625a7a426, burst_en=1 throughout.
  - Required: ROM7_w=1 for 4 cycles with outputs 0000000000000001, 0400000000000400, 0000001fffffffe0, 00007fff7fff8000.
  - Then ROM7_w=2 for 4 cycles with outputs 0000000000000001, 840fa37ec53a39e1, 00000040003fffc0, 2e60ca9625a7a426.
  - Then done=1 for one cycle.
- Input stalls: in_valid toggled 1,0,0,1,1,0,1.
  - Required: 4 words captured, buffer order preserved, the same 8-cycle burst with no gap.
- Burst gating: group filled with burst_en=0 for 10 cycles.
  - Required: in_ready=0, ROM7_w=0 and busy=1 throughout.
  - burst_en rises: the burst begins the following cycle.
- abort during FILL after 2 words.
  - Required: state IDLE, no ROM7_w activity.
  - A new group of 4 words then produces a burst containing only the new words.
- abort asserted on the 3rd cycle of BURST_HI.
  - Required: the burst still completes all 8 cycles and done pulses once.
- rst_n low on the 2nd BURST_LO cycle.
  - Required: ROM7_w=0, horizontal_tf_out=0, in_ready=0 immediately.
  - After release: state IDLE and in_ready=1 on the next cycle.
